// File: rtl/atan2_arbiter.sv
// atan2_arbiter: round-robin sharing of one fully pipelined atan2 unit
// between N_REQ requesters. Each issued operation carries a {valid, id}
// tag down a LATENCY-deep shift register so the Q3.13 result coming back
// from the atan2 can be routed to the requester that issued it.
// Optional per-requester issue counters are enabled by defining
// ATAN2_ARB_STATS_EN, which adds the stat_count output.
module atan2_arbiter #(
  parameter int WIDTH   = 16,
  parameter int N_REQ   = 4,
  parameter int LATENCY = 4,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_y,
  input  logic [N_REQ*WIDTH-1:0]   req_x,
  output logic [WIDTH-1:0]         atan_y,
  output logic [WIDTH-1:0]         atan_x,
  input  logic [15:0]              atan_result,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [IW-1:0]            resp_id,
  output logic [15:0]              resp_data
`ifdef ATAN2_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]      stat_count
`endif
);

  // One extra bit so rr + offset can exceed N_REQ before the wrap.
  localparam logic [IW:0] N_REQ_W = (IW+1)'(N_REQ);
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);

  logic [IW-1:0]    rr;
  logic             grant_any;
  logic [IW-1:0]    grant_id;
  logic [IW:0]      cand;
  logic [N_REQ-1:0] grant_oh;
  logic             issue;

  logic [LATENCY-1:0] tag_valid;
  logic [IW-1:0]      tag_id [LATENCY];

  // Round-robin search: walk offsets from high to low so the candidate
  // closest to the rr pointer is the one left standing.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr} + (IW+1)'(off);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end
      if (req_valid[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[IW-1:0];
      end
    end
  end

  // Grant is suppressed during flush and while reset is held, so nothing
  // is accepted that would later be dropped.
  always_comb begin
    issue     = grant_any & ~flush & rst_n;
    grant_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
    req_ready = issue ? grant_oh : '0;
    atan_y    = issue ? req_y[grant_id*WIDTH +: WIDTH] : '0;
    atan_x    = issue ? req_x[grant_id*WIDTH +: WIDTH] : '0;
  end

  // Pointer moves just past the requester that transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (issue) begin
      rr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag shift register tracks which atan2 slots hold live operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1] & ~flush;
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Response register: id and data only move on a live result and hold
  // otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (flush) begin
      resp_valid <= '0;
    end else if (tag_valid[LATENCY-1]) begin
      resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << tag_id[LATENCY-1];
      resp_id    <= tag_id[LATENCY-1];
      resp_data  <= atan_result;
    end else begin
      resp_valid <= '0;
    end
  end

`ifdef ATAN2_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      logic [15:0] cnt;
      // Saturating issue counter; flush does not touch it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (req_ready[gi] && req_valid[gi] && (cnt != 16'hFFFF)) begin
          cnt <= cnt + 16'd1;
        end
      end
      assign stat_count[gi*16 +: 16] = cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_atan2_arbiter.sv
// Directed testbench for atan2_arbiter. A behavioural atan2 stand-in
// looks up the hand-computed Q3.13 results for the operand pairs used and
// delays them by LATENCY edges, counting the capture edge.
module tb_atan2_arbiter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_y = '0;
  logic [N*W-1:0] req_x = '0;
  logic [W-1:0]   atan_y;
  logic [W-1:0]   atan_x;
  logic [15:0]    atan_result;
  logic [N-1:0]   resp_valid;
  logic [1:0]     resp_id;
  logic [15:0]    resp_data;
`ifdef ATAN2_ARB_STATS_EN
  logic [N*16-1:0] stat_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit quiet = 1'b0;

  logic [15:0] exp_data [N];
  logic [15:0] pipe [L];

  atan2_arbiter #(.WIDTH(W), .N_REQ(N), .LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_y      (req_y),
    .req_x      (req_x),
    .atan_y     (atan_y),
    .atan_x     (atan_x),
    .atan_result(atan_result),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
`ifdef ATAN2_ARB_STATS_EN
    ,
    .stat_count (stat_count)
`endif
  );

  always #5 clk = ~clk;

  // Hand-computed atan2(y, x) in Q3.13 for the operand pairs in use.
  function automatic logic [15:0] lut(input logic [15:0] y, input logic [15:0] x);
    case ({y, x})
      32'h0001_0001: lut = 16'h1922;  //  pi/4
      32'h0003_0000: lut = 16'h3244;  //  pi/2
      32'h0000_FFFB: lut = 16'h6488;  //  pi
      32'hFFFE_FFFE: lut = 16'hB49A;  // -3pi/4
      32'h0000_0005: lut = 16'h0000;  //  0
      default:       lut = 16'h7777;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < L; i++) pipe[i] = 16'h0;
  end

  always @(posedge clk) begin
    pipe[0] <= lut(atan_y, atan_x);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign atan_result = pipe[L-1];

  always @(negedge clk) begin
    if (!quiet && (|resp_valid))
      $display("resp id=%0d valid=%b data=%h", resp_id, resp_valid, resp_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_data[0] = 16'h1922;
    exp_data[1] = 16'h3244;
    exp_data[2] = 16'h6488;
    exp_data[3] = 16'hB49A;

    // ---------- reset state ----------
    rst_n = 1'b0;
    req_valid = 4'b0100;
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_data", 32'(resp_data), 32'h0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // ---------- single request: requester 2, (0,5) ----------
    req_y = {16'hFFFE, 16'h0000, 16'h0003, 16'h0001};
    req_x = {16'hFFFE, 16'h0005, 16'h0000, 16'h0001};
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_atan_x", 32'(atan_x), 32'h5);
    tick();
    req_valid = '0;
    check("single_lat0", 32'(resp_valid), 32'h0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("single_lat", 32'(resp_valid), 32'h0);
    end
    tick();
    $display("txn single: id=%0d data=%h", resp_id, resp_data);
    check("single_valid", 32'(resp_valid), 32'h4);
    check("single_id", 32'(resp_id), 32'h2);
    check("single_data", 32'(resp_data), 32'h0);
    tick();
    check("single_drop", 32'(resp_valid), 32'h0);
    check("single_hold_id", 32'(resp_id), 32'h2);

    // ---------- all four valid from reset ----------
    req_x = {16'hFFFE, 16'hFFFB, 16'h0000, 16'h0001};
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("all_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 9) req_valid = '0;
      if (e <= 8) check("all_grant", 32'(req_ready), 32'(1 << ((e - 1) % 4)));
      tick();
      if (e >= 5) begin
        check("all_resp_valid", 32'(resp_valid), 32'(1 << ((e - 5) % 4)));
        check("all_resp_id", 32'(resp_id), 32'((e - 5) % 4));
        check("all_resp_data", 32'(resp_data), 32'(exp_data[(e - 5) % 4]));
      end else begin
        check("all_resp_idle", 32'(resp_valid), 32'h0);
      end
    end
    tick();
    check("all_resp_end", 32'(resp_valid), 32'h0);

    // ---------- fairness: 0 and 3 held (rr is 0 here) ----------
    req_valid = 4'b1001;
    for (int g = 0; g < 6; g++) begin
      #1;
      check("fair_grant", 32'(req_ready), (g % 2 == 0) ? 32'h1 : 32'h8);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // ---------- flush (rr is 0 here) ----------
    req_valid = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      #1;
      check("flush_issue", 32'(req_ready), 32'h2);
      tick();
    end
    req_valid = 4'b1000;
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(req_ready), 32'h0);
    tick();
    flush = 1'b0;
    req_valid = '0;
    check("flush_resp0", 32'(resp_valid), 32'h0);
    for (int t = 0; t < 6; t++) begin
      tick();
      check("flush_resp", 32'(resp_valid), 32'h0);
    end
    // rr must still be 2: searching from 2 reaches 3 before 0
    req_valid = 4'b1001;
    #1;
    check("post_flush_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    repeat (3) tick();
    check("post_flush_early", 32'(resp_valid), 32'h0);
    tick();
    check("post_flush_valid", 32'(resp_valid), 32'h8);
    check("post_flush_id", 32'(resp_id), 32'h3);
    check("post_flush_data", 32'(resp_data), 32'hB49A);

    // ---------- reset mid-flight (rr is 0 here) ----------
    req_valid = 4'b0011;
    repeat (5) tick();
    check("mid_pre_resp", 32'(resp_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_id", 32'(resp_id), 32'h0);
    check("mid_rst_data", 32'(resp_data), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("mid_no_stale", 32'(resp_valid), 32'h0);
    end
    req_valid = 4'b1001;
    #1;
    check("mid_rr_zero", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("mid_resp_valid", 32'(resp_valid), 32'h1);
    check("mid_resp_data", 32'(resp_data), 32'h1922);

`ifdef ATAN2_ARB_STATS_EN
    // ---------- saturating issue counters ----------
    quiet = 1'b1;
    rst_n = 1'b0;
    #1;
    check("stat_rst", 32'(stat_count[15:0]), 32'h0);
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = 4'b0010;
    repeat (70000) tick();
    req_valid = '0;
    tick();
    check("stat_s0", 32'(stat_count[15:0]), 32'h3);
    check("stat_s1", 32'(stat_count[31:16]), 32'hFFFF);
    check("stat_s2", 32'(stat_count[47:32]), 32'h0);
    check("stat_s3", 32'(stat_count[63:48]), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stat_flush_s0", 32'(stat_count[15:0]), 32'h3);
    check("stat_flush_s1", 32'(stat_count[31:16]), 32'hFFFF);
    quiet = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
